// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the instruction-fetch port, the data-stage port and the
// single-port memory that the arbiter multiplexes onto.
// slave modport: arbiter side; master modport: requesters + memory side.
interface mips_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // Instruction fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // Data-stage port
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    // Single-port memory (read data one cycle after a read enable)
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Arbitrates IF and DM accesses onto one single-port memory; DM has priority
// but IF wins after STARVE_LIMIT consecutive losses. Grant latency 0, read
// data returns 1 cycle after grant. Backpressure: a losing requester simply
// sees gnt=0 and must hold its request; halted blocks IF grants entirely.
// Ports: clk1, rst_n (async active-low), halted, bus (slave modport), conflict_cnt.
module mips_mem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  halted,
    mips_mem_arbiter_if.slave     bus,
    output logic [15:0]           conflict_cnt
);

    localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Who owns the read data coming back from memory next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t         owner_q;
    owner_t         owner_d;
    logic [SW-1:0]  starve_cnt;
    logic [SW-1:0]  starve_nxt;
    logic [15:0]    conflict_nxt;

    logic           if_live;
    logic           starved;
    logic           if_gnt_w;
    logic           dm_gnt_w;
    logic           if_rvalid_w;
    logic           dm_rvalid_w;

    // ------------------------------------------------------------------
    // Grant decision (combinational). rst_n gates the grants so nothing
    // reaches the memory while the block is held in reset.
    // ------------------------------------------------------------------
    always_comb begin
        if_live  = bus.if_req && !halted;
        starved  = (starve_cnt == STARVE_MAX);
        if_gnt_w = 1'b0;
        dm_gnt_w = 1'b0;
        if (rst_n) begin
            if (if_live && (!bus.dm_req || starved)) begin
                if_gnt_w = 1'b1;
            end else if (bus.dm_req) begin
                dm_gnt_w = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: starvation counter, return owner, conflict counter.
    // ------------------------------------------------------------------
    always_comb begin
        starve_nxt   = starve_cnt;
        owner_d      = OWN_NONE;
        conflict_nxt = conflict_cnt;

        // The counter only tracks an unbroken run of IF losses; any gap in
        // the fetch request, a halt, or a won fetch restarts the run.
        if (!bus.if_req || halted || if_gnt_w) begin
            starve_nxt = '0;
        end else if (dm_gnt_w && (starve_cnt != STARVE_MAX)) begin
            starve_nxt = starve_cnt + 1'b1;
        end

        // Fetches are always reads; DM writes return nothing.
        if (if_gnt_w) begin
            owner_d = OWN_IF;
        end else if (dm_gnt_w && !bus.dm_we) begin
            owner_d = OWN_DM;
        end

        // Counts raw contention, independent of halted.
        if (bus.if_req && bus.dm_req && (conflict_cnt != 16'hFFFF)) begin
            conflict_nxt = conflict_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt   <= '0;
            owner_q      <= OWN_NONE;
            conflict_cnt <= 16'd0;
        end else begin
            starve_cnt   <= starve_nxt;
            owner_q      <= owner_d;
            conflict_cnt <= conflict_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. rvalid decodes directly from the registered owner, so a
    // reset clears any pending return immediately.
    // ------------------------------------------------------------------
    always_comb begin
        if_rvalid_w   = (owner_q == OWN_IF);
        dm_rvalid_w   = (owner_q == OWN_DM);

        bus.if_gnt    = if_gnt_w;
        bus.dm_gnt    = dm_gnt_w;
        bus.if_rvalid = if_rvalid_w;
        bus.dm_rvalid = dm_rvalid_w;
        bus.if_rdata  = if_rvalid_w ? bus.mem_rdata : '0;
        bus.dm_rdata  = dm_rvalid_w ? bus.mem_rdata : '0;

        // Idle memory cycles drive a clean all-zero command.
        bus.mem_en    = if_gnt_w | dm_gnt_w;
        bus.mem_we    = dm_gnt_w & bus.dm_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (dm_gnt_w) begin
            bus.mem_addr = bus.dm_addr;
        end else if (if_gnt_w) begin
            bus.mem_addr = bus.if_addr;
        end
        if (if_gnt_w | dm_gnt_w) begin
            bus.mem_wdata = bus.dm_wdata;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mips_mem_arbiter;

    logic        clk1;
    logic        rst_n;
    logic        halted;
    logic [15:0] conflict_cnt;

    mips_mem_arbiter_if #(.AW(10), .DW(32)) bus();

    mips_mem_arbiter #(.AW(10), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .halted       (halted),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];

    // Memory model: synchronous single-port RAM, read data one cycle later.
    logic [31:0] mem [0:1023];
    always @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h2801000a;
            mem[1] <= 32'h28020014;
            mem[2] <= 32'h28030019;
            mem[3] <= 32'h0ce77800;
            bus.mem_rdata <= 32'd0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a return is presented.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk1);
            if (bus.if_rvalid) begin
                if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'(bus.if_rvalid), 32'd0);
                else begin
                    e = if_q.pop_front();
                    chk("if_rdata", bus.if_rdata, e);
                end
            end else begin
                chk("if_rdata_idle", bus.if_rdata, 32'd0);
            end
            if (bus.dm_rvalid) begin
                if (dm_q.size() == 0) chk("dm_rvalid_unexpected", 32'(bus.dm_rvalid), 32'd0);
                else begin
                    e = dm_q.pop_front();
                    chk("dm_rdata", bus.dm_rdata, e);
                end
            end else begin
                chk("dm_rdata_idle", bus.dm_rdata, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive_idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        halted       = 1'b0;
    endtask

    logic [31:0] if_exp [4] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800};
    int exp_conf;

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
        chk({tag, "_dm_gnt"},    32'(bus.dm_gnt),    32'd0);
        chk({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
        chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        chk({tag, "_dm_rvalid"}, 32'(bus.dm_rvalid), 32'd0);
        chk({tag, "_if_rdata"},  bus.if_rdata,       32'd0);
        chk({tag, "_dm_rdata"},  bus.dm_rdata,       32'd0);
        chk({tag, "_conflict"},  32'(conflict_cnt),  32'd0);
    endtask

    initial begin
        // ---- reset with both requests asserted ----
        rst_n = 1'b0;
        drive_idle();
        bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd5;
        #2;
        chk_all_zero("reset");
        repeat (3) @(posedge clk1);
        #1;
        drive_idle();
        rst_n = 1'b1;
        exp_conf = 0;

        // ---- IF only, back-to-back fetches of words 0..3 ----
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            bus.if_req  = 1'b1;
            bus.if_addr = 10'(i);
            #1;
            chk("if_only_if_gnt",   32'(bus.if_gnt),   32'd1);
            chk("if_only_dm_gnt",   32'(bus.dm_gnt),   32'd0);
            chk("if_only_mem_en",   32'(bus.mem_en),   32'd1);
            chk("if_only_mem_addr", 32'(bus.mem_addr), 32'(i));
            if_q.push_back(if_exp[i]);
        end
        step();
        drive_idle();

        // ---- DM write 0x1E to addr 10, then read it back ----
        step();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd10; bus.dm_wdata = 32'h1E;
        #1;
        chk("dm_wr_gnt",       32'(bus.dm_gnt),   32'd1);
        chk("dm_wr_mem_we",    32'(bus.mem_we),   32'd1);
        chk("dm_wr_mem_addr",  32'(bus.mem_addr), 32'd10);
        chk("dm_wr_mem_wdata", bus.mem_wdata,     32'h1E);
        step();
        bus.dm_we = 1'b0; bus.dm_wdata = 32'd0;
        #1;
        chk("dm_rd_gnt",    32'(bus.dm_gnt), 32'd1);
        chk("dm_rd_mem_we", 32'(bus.mem_we), 32'd0);
        dm_q.push_back(32'h1E);
        step();
        drive_idle();
        step();

        // ---- both requesting: DM x4 then IF, repeating ----
        bus.if_req = 1'b1; bus.if_addr = 10'd1;
        bus.dm_req = 1'b1; bus.dm_addr = 10'd10;
        for (int k = 0; k < 12; k++) begin
            if (k != 0) step();
            #1;
            chk("starve_if_gnt", 32'(bus.if_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk("starve_dm_gnt", 32'(bus.dm_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
            chk("starve_conflict_cnt", 32'(conflict_cnt), 32'(exp_conf));
            if (k % 5 == 4) if_q.push_back(32'h28020014);
            else            dm_q.push_back(32'h1E);
            exp_conf++;
        end

        // ---- halted: IF blocked, DM unaffected, starvation run cleared ----
        step();
        halted = 1'b1;
        #1;
        chk("halt_if_gnt", 32'(bus.if_gnt), 32'd0);
        chk("halt_dm_gnt", 32'(bus.dm_gnt), 32'd1);
        dm_q.push_back(32'h1E);
        exp_conf++;
        step();
        bus.dm_req = 1'b0;
        #1;
        chk("halt_starve_cnt", 32'(dut.starve_cnt), 32'd0);
        chk("halt_conflict",   32'(conflict_cnt),   32'(exp_conf));
        chk("halt_if_gnt2",    32'(bus.if_gnt),     32'd0);
        chk("halt_mem_en",     32'(bus.mem_en),     32'd0);
        step();
        halted = 1'b0; bus.if_addr = 10'd2;
        #1;
        chk("unhalt_if_gnt", 32'(bus.if_gnt), 32'd1);
        if_q.push_back(32'h28030019);
        step();
        drive_idle();
        step();

        // ---- reset right after a read grant: return discarded ----
        bus.dm_req = 1'b1; bus.dm_addr = 10'd10;
        #1;
        chk("rst_rd_gnt", 32'(bus.dm_gnt), 32'd1);
        @(posedge clk1);
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.dm_we = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        repeat (2) @(posedge clk1);
        #1;
        drive_idle();
        rst_n = 1'b1;
        exp_conf = 0;
        repeat (3) step();

        // ---- conflict counter saturation (IF held off by halted) ----
        halted = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 10'd3;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd20;
        repeat (65534) step();
        chk("sat_fffe", 32'(conflict_cnt), 32'h0000FFFE);
        step();
        chk("sat_ffff", 32'(conflict_cnt), 32'h0000FFFF);
        repeat (2) step();
        chk("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);
        drive_idle();
        repeat (3) step();

        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("dm_q_drained", 32'(dm_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
